// File: rtl/speed_round_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// speed_round_ctrl_if : control, verdict and result bus of the speed round.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
interface speed_round_ctrl_if #(
   parameter int TIMER_W = 16
);
   logic               start;
   logic               abort;
   logic               speed_tie;
   logic               speed_right;
   logic               speedRound;
   logic               speedExit;
   logic               busy;
   logic [TIMER_W-1:0] time_left;
   logic               result_valid;
   logic               win_right;
   logic               win_left;
   logic               win_tie;
   logic [3:0]         score_right;
   logic [3:0]         score_left;

   // Game FSM / push counter side
   modport master (
      output start, abort, speed_tie, speed_right,
      input  speedRound, speedExit, busy, time_left, result_valid,
      input  win_right, win_left, win_tie, score_right, score_left
   );

   // Sequencer side
   modport slave (
      input  start, abort, speed_tie, speed_right,
      output speedRound, speedExit, busy, time_left, result_valid,
      output win_right, win_left, win_tie, score_right, score_left
   );
endinterface
`default_nettype wire

// File: rtl/speed_round_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// speed_round_ctrl : speed-round window sequencer, verdict sampler, win tally.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module speed_round_ctrl #(
   parameter int ROUND_CYCLES  = 200,
   parameter int SETTLE_CYCLES = 4,
   parameter int TIMER_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   speed_round_ctrl_if.slave  bus
);

   localparam logic [TIMER_W-1:0] ROUND_LOAD  = TIMER_W'(ROUND_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SETTLE_LOAD = TIMER_W'(SETTLE_CYCLES - 1);
   localparam logic [3:0]         SCORE_MAX   = 4'd15;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARM    = 3'd1,
      RUN    = 3'd2,
      SETTLE = 3'd3,
      REPORT = 3'd4,
      CLEAR  = 3'd5
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [TIMER_W-1:0] timer;
   logic [TIMER_W-1:0] timer_next;
   logic               publish;
   logic               from_report;
   logic               win_right;
   logic               win_left;
   logic               win_tie;
   logic [3:0]         score_right;
   logic [3:0]         score_left;
   logic               verdict_tie;
   logic               verdict_right;
   logic               verdict_left;

   // Tie dominates; right only counts when the counts are not equal.
   assign verdict_tie   = bus.speed_tie;
   assign verdict_right = !bus.speed_tie && bus.speed_right;
   assign verdict_left  = !bus.speed_tie && !bus.speed_right;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         timer <= '0;
      end else begin
         state <= state_next;
         timer <= timer_next;
      end
   end

   always_comb begin
      state_next = state;
      timer_next = timer;
      publish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = ARM;
            end
         end
         ARM: begin
            if (bus.abort) begin
               state_next = CLEAR;
               timer_next = '0;
            end else begin
               state_next = RUN;
               timer_next = ROUND_LOAD;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_next = CLEAR;
               timer_next = '0;
            end else if (timer == '0) begin
               state_next = SETTLE;
               timer_next = SETTLE_LOAD;
            end else begin
               timer_next = timer - 1'b1;
            end
         end
         SETTLE: begin
            if (bus.abort) begin
               state_next = CLEAR;
               timer_next = '0;
            end else if (timer == '0) begin
               state_next = REPORT;
            end else begin
               timer_next = timer - 1'b1;
            end
         end
         REPORT: begin
            publish    = 1'b1;
            state_next = CLEAR;
         end
         CLEAR: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            timer_next = '0;
         end
      endcase
   end

   // Verdict and tallies; from_report marks the CLEAR that follows a REPORT.
   always_ff @(posedge clk) begin
      if (rst) begin
         from_report <= 1'b0;
         win_right   <= 1'b0;
         win_left    <= 1'b0;
         win_tie     <= 1'b0;
         score_right <= '0;
         score_left  <= '0;
      end else begin
         from_report <= publish;
         if (publish) begin
            win_right <= verdict_right;
            win_left  <= verdict_left;
            win_tie   <= verdict_tie;
            if (verdict_right && (score_right != SCORE_MAX)) begin
               score_right <= score_right + 4'd1;
            end
            if (verdict_left && (score_left != SCORE_MAX)) begin
               score_left <= score_left + 4'd1;
            end
         end
      end
   end

   assign bus.speedRound   = (state == RUN);
   assign bus.speedExit    = (state == ARM) || (state == CLEAR);
   assign bus.busy         = (state != IDLE);
   assign bus.time_left    = (state == RUN) ? timer : '0;
   assign bus.result_valid = (state == CLEAR) && from_report;
   assign bus.win_right    = win_right;
   assign bus.win_left     = win_left;
   assign bus.win_tie      = win_tie;
   assign bus.score_right  = score_right;
   assign bus.score_left   = score_left;

endmodule
`default_nettype wire

// File: tb/tb_speed_round_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_speed_round_ctrl : randomized bench with result scoreboard and monitor.
// Revision 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_speed_round_ctrl;

   localparam int R   = 8;
   localparam int S   = 4;
   localparam int TW  = 16;
   localparam int CLR = R + S + 3;

   typedef struct packed {
      logic       wr;
      logic       wl;
      logic       wt;
      logic [3:0] sr;
      logic [3:0] sl;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   model_r = 0;
   int   model_l = 0;
   res_t exp_q[$];
   res_t held = '0;

   always #5 clk = ~clk;

   speed_round_ctrl_if #(.TIMER_W(TW)) bus ();

   speed_round_ctrl #(
      .ROUND_CYCLES (R),
      .SETTLE_CYCLES(S),
      .TIMER_W      (TW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
      end
   endtask

   // Result monitor: pops the scoreboard on every publish, and checks that
   // flags and scores stay at the last published value in between.
   initial begin
      res_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            held = '0;
         end else begin
            if (bus.result_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", 64'd1, 64'd0);
               end else begin
                  e = exp_q.pop_front();
                  held = e;
               end
            end
            check("flags_scores",
                  {bus.win_right, bus.win_left, bus.win_tie, bus.score_right, bus.score_left},
                  held);
         end
      end
   end

   function automatic logic [19:0] strobes_now();
      return {bus.busy, bus.speedRound, bus.speedExit, bus.result_valid, bus.time_left};
   endfunction

   // One round: start in cycle 0; optional abort / ignored restart / reset
   // asserted during the given cycle (0 = none). Verdict t/r presented only
   // during the REPORT cycle, random noise elsewhere.
   task automatic do_round(input bit t, input bit r, input int abort_at,
                           input int restart_at, input int rst_at);
      int          last;
      bit          aborted;
      bit          reset_hit;
      res_t        e;
      logic [1:0]  noise;
      logic [19:0] expv;
      bit          b, rnd, ex, rv;
      int          tl;
      aborted   = (abort_at >= 1) && (abort_at <= R + S + 1);
      reset_hit = (rst_at > 0);
      last      = reset_hit ? rst_at + 1 : (aborted ? abort_at + 2 : R + S + 4);
      if (reset_hit) begin
         model_r = 0;
         model_l = 0;
      end else if (!aborted) begin
         e = '0;
         if (t) e.wt = 1'b1;
         else if (r) begin e.wr = 1'b1; model_r = (model_r < 15) ? model_r + 1 : 15; end
         else begin e.wl = 1'b1; model_l = (model_l < 15) ? model_l + 1 : 15; end
         e.sr = 4'(model_r);
         e.sl = 4'(model_l);
         exp_q.push_back(e);
      end
      noise = 2'($urandom_range(0, 3));
      {bus.speed_tie, bus.speed_right} = noise;
      bus.start = 1'b1;
      bus.abort = 1'b0;
      for (int c = 1; c <= last; c++) begin
         @(posedge clk);
         #1;
         bus.start = (c == restart_at);
         bus.abort = (c == abort_at);
         rst       = (c == rst_at);
         noise     = 2'($urandom_range(0, 3));
         if (c == R + S + 2) {bus.speed_tie, bus.speed_right} = {t, r};
         else                {bus.speed_tie, bus.speed_right} = noise;
         @(negedge clk);
         b   = (c >= 1) && (c <= CLR);
         rnd = (c >= 2) && (c <= R + 1);
         ex  = (c == 1) || (c == CLR);
         rv  = (c == CLR);
         tl  = rnd ? (R + 1 - c) : 0;
         expv = {b, rnd, ex, rv, 16'(tl)};
         if (reset_hit && c > rst_at) expv = '0;
         else if (aborted && c == abort_at + 1) expv = {1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
         else if (aborted && c > abort_at + 1) expv = '0;
         check($sformatf("strobes_c%0d", c), strobes_now(), expv);
      end
   endtask

   initial begin
      int ab;
      int rs;
      bus.start       = 1'b0;
      bus.abort       = 1'b0;
      bus.speed_tie   = 1'b0;
      bus.speed_right = 1'b0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.abort = 1'b1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_strobes", strobes_now(), 20'd0);
      check("reset_flags",
            {bus.win_right, bus.win_left, bus.win_tie, bus.score_right, bus.score_left}, 64'd0);
      @(posedge clk);
      #1;
      bus.abort = 1'b0;
      @(negedge clk);
      check("idle_abort_ignored", strobes_now(), 20'd0);

      do_round(1'b0, 1'b1, 0, 0, 0);           // right win
      do_round(1'b1, 1'b1, 0, 0, 0);           // tie dominates right
      do_round(1'b0, 1'b0, 5, 0, 0);           // abort mid-RUN
      do_round(1'b0, 1'b1, 1, 0, 0);           // abort in ARM
      do_round(1'b0, 1'b1, R + 1, 0, 0);       // abort beats window expiry
      do_round(1'b0, 1'b1, R + S + 1, 0, 0);   // abort in last SETTLE cycle
      do_round(1'b0, 1'b1, R + S + 2, 0, 0);   // abort in REPORT ignored
      do_round(1'b1, 1'b0, CLR, 0, 0);         // abort in CLEAR ignored
      do_round(1'b0, 1'b1, 0, 4, 0);           // start during RUN ignored
      do_round(1'b0, 1'b1, 0, CLR, 0);         // start during CLEAR ignored
      for (int i = 0; i < 16; i++) begin
         do_round(1'b0, 1'b0, 0, 0, 0);        // left wins up to saturation
      end
      do_round(1'b0, 1'b1, 0, 0, R + 3);       // reset in SETTLE
      do_round(1'b0, 1'b1, 0, 0, 0);           // full round after reset

      for (int i = 0; i < 24; i++) begin
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, CLR)) : 0;
         rs = int'($urandom_range(2, CLR));
         if ((ab >= 1) && (ab <= R + S + 1) && (rs > ab + 1)) rs = 0;
         do_round(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), ab, rs, 0);
      end

      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/speed_round_ctrl.md
# speed_round_ctrl

Sequencer for the tug-of-war speed round, sitting directly upstream and downstream of the push counter. It generates the `speedRound` counting window and `speedExit` clear pulses that the push counter consumes. After the push-counter pipeline settles, it samples the counter's `speed_right`/`speed_tie` verdict. It then reports a one-cycle registered result to the game FSM and keeps a saturating per-side win tally.

## Interface
- `ROUND_CYCLES`, 200: length of counting window in clk cycles; legal range 1..2^TIMER_W.
- `SETTLE_CYCLES`, 4: wait after the window closes before sampling the verdict; ≥1. Covers sync + edge-detect + registered compare latency.
- `TIMER_W`, 16: width of the internal timer and `time_left`.
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a speed round; sampled only in IDLE.
- `abort`  in  1  cancel a round in progress; no result is produced.
- `speed_tie`  in  1  push-counter verdict: counts equal.
- `speed_right`  in  1  push-counter verdict: right count greater.
- `speedRound`  out  1  counting enable to the push counter.
- `speedExit`  out  1  one-cycle clear pulse to the push counter.
- `busy`  out  1  high in every state except IDLE.
- `time_left`  out  TIMER_W  remaining window cycles; 0 outside RUN.
- `result_valid`  out  1  one-cycle pulse when a verdict is published.
- `win_right`, `win_left`, `win_tie`  out  1 each  one-hot verdict; held until the next publish.
- `score_right`, `score_left`  out  4 each  saturating round-win tallies.

## Operation
- States: IDLE, ARM, RUN, SETTLE, REPORT, CLEAR.
- All outputs are decoded from registers only; there is no combinational path from inputs to outputs.
- IDLE: all strobes are low. `start`=1 → ARM. `abort` is ignored.
- ARM: one cycle with `speedExit`=1 to clear stale counts. Loads timer = ROUND_CYCLES-1. → RUN.
- RUN: `speedRound`=1 and `time_left`=timer. Timer decrements each cycle. At timer==0 → SETTLE and load timer = SETTLE_CYCLES-1.
- SETTLE: `speedRound`=0. Timer decrements. At 0 → REPORT.
- REPORT (one cycle): samples the verdict.
  - `speed_tie`=1 → tie, regardless of `speed_right`.
  - else `speed_right`=1 → right.
  - else → left.
  - Loads the win flags and increments the winner's score (tie: neither). → CLEAR.
- CLEAR (one cycle): `speedExit`=1. `result_valid`=1 only if entered from REPORT. → IDLE.
- `abort`=1 in ARM, RUN or SETTLE → CLEAR next cycle.
  - `result_valid` stays 0; win flags and scores are unchanged.
  - `abort` has priority over timer expiry.
- `abort` in REPORT or CLEAR is ignored; the round completes.
- `start` outside IDLE is ignored and is not queued.
- `start` and `abort` both high in IDLE: the round starts (abort is ignored in IDLE).
- Scores saturate at 15; a further win leaves the score at 15. Win flags are still updated.
- Win flags are exactly one-hot after the first publish and all zero before it.
- `rst`: state → IDLE; timer, `time_left`, win flags and scores → 0; all strobes → 0.
  - Reset mid-round drops `speedRound` at that edge.
  - No `speedExit` is issued; the push counter shares `rst`.

## Timing
- Cycle n is the interval after rising edge n. `start`=1 is sampled at edge 0.
- `busy`=1 and `speedExit`=1 in cycle 1 (ARM).
- `speedRound`=1 for exactly ROUND_CYCLES cycles: cycles 2 .. R+1.
- `time_left` counts R-1 down to 0 across those cycles.
- SETTLE occupies cycles R+2 .. R+S+1. The verdict is sampled at the end of REPORT, cycle R+S+2.
- CLEAR is cycle R+S+3: `result_valid`=1, `speedExit`=1, and the new win flags and scores are visible.
- IDLE in cycle R+S+4 with `busy`=0. The earliest next `start` is sampled at edge R+S+4.
- Round-to-round period is R+S+4 cycles.
- `abort` sampled at edge k during ARM/RUN/SETTLE → CLEAR in cycle k+1 → IDLE in cycle k+2.

## Test plan
- R=8, S=4, push counter reporting right; pulse `start` → `speedExit` in cycle 1, `speedRound` in cycles 2–9, `result_valid` + `speedExit` in cycle 15, `win_right`=1, `score_right`=1, `busy`=0 from cycle 16.
- Verdict inputs `speed_tie`=1 and `speed_right`=1 together at REPORT → `win_tie`=1 only; both scores unchanged.
- `abort` sampled at edge 5 (mid-RUN) → `speedRound`=0 and `speedExit`=1 in cycle 6, IDLE in cycle 7; `result_valid` never asserts; win flags and scores unchanged.
- 16 consecutive left wins → `score_left` goes 1..15 then stays 15; the 16th publish still pulses `result_valid` with `win_left`=1.
- `start` re-asserted during RUN, and in the same cycle as CLEAR → ignored; exactly one `result_valid` per accepted start.
- `rst` asserted in SETTLE → next cycle: IDLE, all outputs 0, no `speedExit`; a following `start` runs a full normal round.
